regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_pkg.sv | 11 +
 rtl/rf_busy_table.sv | 62 ++++++
 rtl/regfile_scoreboard.sv | 121 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with issue scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned R0_IDX     = 0;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/rf_busy_table.sv
// Per-register busy bits: reservation grant, write-back clearing and busy population count.
module rf_busy_table
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic [ADDR_W-1:0] rd_a_addr_i,
  input  logic [ADDR_W-1:0] rd_b_addr_i,
  output logic              rsv_ok_o,
  output logic              rd_a_busy_o,
  output logic              rd_b_busy_o,
  output logic [ADDR_W:0]   busy_count_o
);

  localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] R0       = ADDR_W'(R0_IDX);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     count_q, count_d;

  always_comb begin
    rsv_ok_o = !rst_i && rsv_en_i &&
               ((rsv_addr_i == R0) || !busy_q[rsv_addr_i] ||
                (wr_en_i && (wr_addr_i == rsv_addr_i)));

    busy_d = busy_q;
    if (wr_en_i && (wr_addr_i != R0)) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    // Applied after the write-back clear so a new producer wins over a retiring one.
    if (rsv_ok_o && (rsv_addr_i != R0)) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[R0_IDX] = 1'b0;

    count_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      count_d = count_d + (ADDR_W + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign rd_a_busy_o  = busy_q[rd_a_addr_i];
  assign rd_b_busy_o  = busy_q[rd_b_addr_i];
  assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read, one-write register file with registered reads, write-first bypass and a
// destination-reservation scoreboard for in-order issue.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned INIT_RAMP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_a_busy,
  output logic              rd_b_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   busy_count
);

  localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] R0       = ADDR_W'(R0_IDX);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rd_a_data_q, rd_a_data_d, rd_b_data_q, rd_b_data_d;
  logic              rd_a_busy_q, rd_a_busy_d, rd_b_busy_q, rd_b_busy_d;
  logic              tbl_a_busy, tbl_b_busy;

  function automatic logic [DATA_W-1:0] reset_val(int unsigned idx);
    if (INIT_RAMP != 0) begin
      return DATA_W'(2 * idx);
    end
    return '0;
  endfunction

  rf_busy_table #(
    .ADDR_W(ADDR_W)
  ) u_busy_table (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .rsv_en_i     (rsv_en),
    .rsv_addr_i   (rsv_addr),
    .rd_a_addr_i  (rd_a_addr),
    .rd_b_addr_i  (rd_b_addr),
    .rsv_ok_o     (rsv_ok),
    .rd_a_busy_o  (tbl_a_busy),
    .rd_b_busy_o  (tbl_b_busy),
    .busy_count_o (busy_count)
  );

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != R0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Read capture; busy comes from the pre-edge table so a same-cycle reservation is not seen.
  always_comb begin
    rd_a_data_d = rd_a_data_q;
    rd_a_busy_d = rd_a_busy_q;
    rd_b_data_d = rd_b_data_q;
    rd_b_busy_d = rd_b_busy_q;
    if (rd_en) begin
      if (rd_a_addr == R0) begin
        rd_a_data_d = '0;
        rd_a_busy_d = 1'b0;
      end else if (wr_en && (wr_addr == rd_a_addr)) begin
        rd_a_data_d = wr_data;
        rd_a_busy_d = 1'b0;
      end else begin
        rd_a_data_d = regs_q[rd_a_addr];
        rd_a_busy_d = tbl_a_busy;
      end
      if (rd_b_addr == R0) begin
        rd_b_data_d = '0;
        rd_b_busy_d = 1'b0;
      end else if (wr_en && (wr_addr == rd_b_addr)) begin
        rd_b_data_d = wr_data;
        rd_b_busy_d = 1'b0;
      end else begin
        rd_b_data_d = regs_q[rd_b_addr];
        rd_b_busy_d = tbl_b_busy;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= reset_val(i);
      end
      rd_a_data_q <= '0;
      rd_b_data_q <= '0;
      rd_a_busy_q <= 1'b0;
      rd_b_busy_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      rd_a_data_q <= rd_a_data_d;
      rd_b_data_q <= rd_b_data_d;
      rd_a_busy_q <= rd_a_busy_d;
      rd_b_busy_q <= rd_b_busy_d;
    end
  end

  assign rd_a_data = rd_a_data_q;
  assign rd_b_data = rd_b_data_q;
  assign rd_a_busy = rd_a_busy_q;
  assign rd_b_busy = rd_b_busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard: expected read results queued at drive time and
// compared after the capturing edge; hand sequences cover saturation and mid-run reset.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [3:0]  rd_a_addr, rd_b_addr;
  logic [15:0] rd_a_data, rd_b_data;
  logic        rd_a_busy, rd_b_busy;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        rsv_ok;
  logic [4:0]  busy_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rd_en;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        wr_en;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        rsv_en;
    logic [3:0]  rsa;
    logic        ok;
    logic [15:0] ad;
    logic        ab;
    logic [15:0] bd;
    logic        bb;
    logic [4:0]  cnt;
  } vec_t;

  typedef struct {
    logic [15:0] ad;
    logic        ab;
    logic [15:0] bd;
    logic        bb;
    logic [4:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[12];

  regfile_scoreboard #(
    .DATA_W    (16),
    .ADDR_W    (4),
    .INIT_RAMP (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_a_addr  (rd_a_addr),
    .rd_b_addr  (rd_b_addr),
    .rd_a_data  (rd_a_data),
    .rd_b_data  (rd_b_data),
    .rd_a_busy  (rd_a_busy),
    .rd_b_busy  (rd_b_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rsv_ok     (rsv_ok),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic re, input logic [3:0] ra, input logic [3:0] rb,
                              input logic we, input logic [3:0] wa, input logic [15:0] wd,
                              input logic se, input logic [3:0] sa, input logic ok,
                              input logic [15:0] ad, input logic ab, input logic [15:0] bd,
                              input logic bb, input logic [4:0] cnt);
    vec_t v;
    v.rd_en = re; v.ra = ra; v.rb = rb; v.wr_en = we; v.wa = wa; v.wd = wd;
    v.rsv_en = se; v.rsa = sa; v.ok = ok; v.ad = ad; v.ab = ab; v.bd = bd; v.bb = bb;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic idle_inputs();
    rd_en = 0; rd_a_addr = 0; rd_b_addr = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rsv_en = 0; rsv_addr = 0;
  endtask

  // Drive one vector at the falling edge, check the grant, queue the post-edge expectation.
  task automatic step(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    rd_en = v.rd_en; rd_a_addr = v.ra; rd_b_addr = v.rb;
    wr_en = v.wr_en; wr_addr = v.wa; wr_data = v.wd;
    rsv_en = v.rsv_en; rsv_addr = v.rsa;
    #1;
    chk({name, ".rsv_ok"}, 32'(rsv_ok), 32'(v.ok));
    e.ad = v.ad; e.ab = v.ab; e.bd = v.bd; e.bb = v.bb; e.cnt = v.cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s.queue: got empty scoreboard, want one entry", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".rd_a_data"}, 32'(rd_a_data), 32'(e.ad));
      chk({name, ".rd_a_busy"}, 32'(rd_a_busy), 32'(e.ab));
      chk({name, ".rd_b_data"}, 32'(rd_b_data), 32'(e.bd));
      chk({name, ".rd_b_busy"}, 32'(rd_b_busy), 32'(e.bb));
      chk({name, ".busy_count"}, 32'(busy_count), 32'(e.cnt));
    end
  endtask

  initial begin
    //           re ra  rb  we wa  wd        se sa  ok ad        ab bd        bb cnt
    tbl[0]  = mk(1, 3,  7,  0, 0,  16'h0000, 0, 4,  0, 16'd6,    0, 16'd14,   0, 0);
    tbl[1]  = mk(1, 5,  6,  1, 5,  16'h1234, 0, 0,  0, 16'h1234, 0, 16'd12,   0, 0);
    tbl[2]  = mk(1, 5,  0,  0, 0,  16'h0000, 0, 0,  0, 16'h1234, 0, 16'd0,    0, 0);
    tbl[3]  = mk(1, 4,  4,  0, 0,  16'h0000, 1, 4,  1, 16'd8,    0, 16'd8,    0, 1);
    tbl[4]  = mk(1, 4,  1,  0, 0,  16'h0000, 1, 4,  0, 16'd8,    1, 16'd2,    0, 1);
    tbl[5]  = mk(1, 4,  9,  1, 4,  16'hBEEF, 1, 4,  1, 16'hBEEF, 0, 16'd18,   0, 1);
    tbl[6]  = mk(1, 4,  0,  0, 0,  16'h0000, 0, 0,  0, 16'hBEEF, 1, 16'd0,    0, 1);
    tbl[7]  = mk(1, 0,  4,  1, 0,  16'hFFFF, 1, 0,  1, 16'd0,    0, 16'hBEEF, 1, 1);
    tbl[8]  = mk(0, 4,  4,  1, 4,  16'h0042, 0, 0,  0, 16'd0,    0, 16'hBEEF, 1, 0);
    tbl[9]  = mk(1, 4,  0,  0, 0,  16'h0000, 0, 0,  0, 16'h0042, 0, 16'd0,    0, 0);
    tbl[10] = mk(1, 15, 14, 0, 0,  16'h0000, 1, 15, 1, 16'd30,   0, 16'd28,   0, 1);
    tbl[11] = mk(1, 15, 3,  1, 3,  16'h7777, 1, 15, 0, 16'd30,   1, 16'h7777, 0, 1);

    idle_inputs();
    rst = 1'b1;
    rsv_en = 1'b1;
    rsv_addr = 4'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rsv_ok", 32'(rsv_ok), 32'd0);
    chk("reset.rd_a_data", 32'(rd_a_data), 32'd0);
    chk("reset.rd_b_busy", 32'(rd_b_busy), 32'd0);
    chk("reset.busy_count", 32'(busy_count), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Fill the remaining registers; R15 is already busy, reads hold their last capture.
    for (int r = 1; r < 15; r++) begin
      step(mk(0, 0, 0, 0, 0, 16'h0000, 1, 4'(r), 1, 16'd30, 1, 16'h7777, 0, 5'(1 + r)),
           $sformatf("fill%0d", r));
    end
    step(mk(1, 1, 15, 0, 0, 16'h0000, 1, 0, 1, 16'd2, 1, 16'd30, 1, 15), "full_r0");

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    rd_en = 1; rd_a_addr = 4'd1; rd_b_addr = 4'd15;
    rsv_en = 1; rsv_addr = 4'd2;
    #1;
    chk("mid.denied", 32'(rsv_ok), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid.busy_count", 32'(busy_count), 32'd0);
    chk("mid.rd_a_busy", 32'(rd_a_busy), 32'd0);
    chk("mid.rd_b_busy", 32'(rd_b_busy), 32'd0);
    chk("mid.rd_a_data", 32'(rd_a_data), 32'd0);
    chk("mid.rsv_ok", 32'(rsv_ok), 32'd0);
    @(posedge clk);
    #1;
    chk("mid.hold_count", 32'(busy_count), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    step(mk(1, 15, 5, 0, 0, 16'h0000, 0, 0, 0, 16'd30, 0, 16'd10, 0, 0), "post_rst_rd");
    step(mk(1, 2, 1, 0, 0, 16'h0000, 1, 15, 1, 16'd4, 0, 16'd2, 0, 1), "post_rst_rsv");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
